// File: rtl/dma_interrupt_event_gen.sv
// Turns per-channel DMA completion strobes into queued, rate-limited interrupt event pulses.
// Optional build macro DMA_IRQ_EVENT_COALESCE_EN collapses the pending queue into a 1-bit flag.
module dma_interrupt_event_gen #(
   parameter int NUM_EVENTS = 4,
   parameter int PULSE_HIGH = 4,
   parameter int PULSE_LOW  = 4,
   parameter int PEND_W     = 5
) (
   input  logic                         sys_clk_i,
   input  logic                         rst_i,
   input  logic [NUM_EVENTS-1:0]        event_strobe_i,
   input  logic [NUM_EVENTS-1:0]        event_en_i,
   input  logic [NUM_EVENTS-1:0]        flush_i,
   input  logic [NUM_EVENTS-1:0]        overflow_clr_i,
   output logic [NUM_EVENTS-1:0]        interrupt_event_o,
   output logic [NUM_EVENTS-1:0]        busy_o,
   output logic [NUM_EVENTS-1:0]        overflow_o,
   output logic [NUM_EVENTS*PEND_W-1:0] pending_cnt_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

`ifdef DMA_IRQ_EVENT_COALESCE_EN
   localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(1);
   localparam logic              OVF_EN   = 1'b0;
`else
   localparam logic [PEND_W-1:0] PEND_MAX = '1;
   localparam logic              OVF_EN   = 1'b1;
`endif

   localparam logic [7:0] HIGH_LD = 8'(PULSE_HIGH - 1);
   localparam logic [7:0] LOW_LD  = 8'(PULSE_LOW - 1);

   genvar k;
   generate
      for (k = 0; k < NUM_EVENTS; k++) begin : g_ch
         state_t            state_q, state_d;
         logic [7:0]        phase_q, phase_d;
         logic [PEND_W-1:0] pend_q, pend_d;
         logic              ovf_q, ovf_d;
         logic              irq_q, busy_q;
         logic              acc, slot, launch, ovf_set;

         always_comb begin
            acc     = event_strobe_i[k] & event_en_i[k];
            slot    = (state_q == ST_IDLE) || ((state_q == ST_GAP) && (phase_q == 8'd0));
            launch  = slot && ((pend_q != '0) || acc) && !flush_i[k];
            ovf_set = 1'b0;
            pend_d  = pend_q;

            // A launch with a queued event takes the oldest; a coincident strobe refills its slot.
            if (flush_i[k]) begin
               pend_d = '0;
            end else if (launch) begin
               if ((pend_q != '0) && !acc) pend_d = pend_q - PEND_W'(1);
            end else if (acc) begin
               if (pend_q == PEND_MAX) ovf_set = OVF_EN;
               else                    pend_d  = pend_q + PEND_W'(1);
            end

            ovf_d = ovf_set | (ovf_q & ~overflow_clr_i[k]);

            state_d = state_q;
            phase_d = phase_q;
            case (state_q)
               ST_IDLE: begin
                  if (launch) begin
                     state_d = ST_HIGH;
                     phase_d = HIGH_LD;
                  end
               end
               ST_HIGH: begin
                  if (phase_q == 8'd0) begin
                     state_d = ST_GAP;
                     phase_d = LOW_LD;
                  end else begin
                     phase_d = phase_q - 8'd1;
                  end
               end
               ST_GAP: begin
                  if (phase_q == 8'd0) begin
                     if (launch) begin
                        state_d = ST_HIGH;
                        phase_d = HIGH_LD;
                     end else begin
                        state_d = ST_IDLE;
                     end
                  end else begin
                     phase_d = phase_q - 8'd1;
                  end
               end
               default: begin
                  state_d = ST_IDLE;
                  phase_d = 8'd0;
               end
            endcase
         end

         always_ff @(posedge sys_clk_i or posedge rst_i) begin
            if (rst_i) begin
               state_q <= ST_IDLE;
               phase_q <= 8'd0;
               pend_q  <= '0;
               ovf_q   <= 1'b0;
               irq_q   <= 1'b0;
               busy_q  <= 1'b0;
            end else begin
               state_q <= state_d;
               phase_q <= phase_d;
               pend_q  <= pend_d;
               ovf_q   <= ovf_d;
               irq_q   <= (state_d == ST_HIGH);
               busy_q  <= (state_d != ST_IDLE) || (pend_d != '0);
            end
         end

         assign interrupt_event_o[k]               = irq_q;
         assign busy_o[k]                          = busy_q;
         assign overflow_o[k]                      = ovf_q;
         assign pending_cnt_o[k*PEND_W +: PEND_W]  = pend_q;
      end
   endgenerate

endmodule

// File: tb/tb_dma_interrupt_event_gen.sv
// Bench for dma_interrupt_event_gen: timeline model of pulse windows and pending queues, plus directed literals.
module tb_dma_interrupt_event_gen;
   localparam int N  = 4;
   localparam int PH = 4;
   localparam int PL = 4;
   localparam int PW = 2;
`ifdef DMA_IRQ_EVENT_COALESCE_EN
   localparam int PMAX   = 1;
   localparam bit OVF_ON = 1'b0;
`else
   localparam int PMAX   = (1 << PW) - 1;
   localparam bit OVF_ON = 1'b1;
`endif

   logic          clk, rst;
   logic [N-1:0]  stb, en, fl, clr;
   logic [N-1:0]  irq_o, busy_o, ovf_o;
   logic [N*PW-1:0] pend_o;

   dma_interrupt_event_gen #(
      .NUM_EVENTS(N), .PULSE_HIGH(PH), .PULSE_LOW(PL), .PEND_W(PW)
   ) u_dut (
      .sys_clk_i(clk),
      .rst_i(rst),
      .event_strobe_i(stb),
      .event_en_i(en),
      .flush_i(fl),
      .overflow_clr_i(clr),
      .interrupt_event_o(irq_o),
      .busy_o(busy_o),
      .overflow_o(ovf_o),
      .pending_cnt_o(pend_o)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int m_start [N];
   int m_pend  [N];
   bit m_ovf   [N];
   int rises   [N];
   logic [N-1:0] prev_irq = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] pend_of(input int ch);
      return 32'(pend_o[ch*PW +: PW]);
   endfunction

   task automatic goto(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Model: a launch at input cycle t owns output cycles t+1 .. t+PH+PL; high for the first PH of them.
   initial begin
      bit acc, free, launch, set;
      for (int ch = 0; ch < N; ch++) begin
         m_start[ch] = -1000; m_pend[ch] = 0; m_ovf[ch] = 1'b0;
      end
      forever begin
         @(posedge clk);
         for (int ch = 0; ch < N; ch++) begin
            if (rst) begin
               m_start[ch] = -1000; m_pend[ch] = 0; m_ovf[ch] = 1'b0;
            end else begin
               acc    = stb[ch] && en[ch];
               free   = (m_start[ch] + PH + PL) <= (cyc + 1);
               launch = free && (m_pend[ch] > 0 || acc) && !fl[ch];
               set    = 1'b0;
               if (launch) m_start[ch] = cyc + 1;
               if (fl[ch]) m_pend[ch] = 0;
               else if (launch) begin
                  if (m_pend[ch] > 0) m_pend[ch] = m_pend[ch] - 1 + (acc ? 1 : 0);
               end else if (acc) begin
                  if (m_pend[ch] == PMAX) set = OVF_ON;
                  else m_pend[ch] = m_pend[ch] + 1;
               end
               m_ovf[ch] = set || (m_ovf[ch] && !clr[ch]);
            end
         end
         cyc = cyc + 1;
      end
   end

   initial begin
      int d;
      logic e_irq, e_busy;
      for (int ch = 0; ch < N; ch++) rises[ch] = 0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            for (int ch = 0; ch < N; ch++) begin
               d      = cyc - m_start[ch];
               e_irq  = (d >= 0) && (d < PH);
               e_busy = ((d >= 0) && (d < PH + PL)) || (m_pend[ch] != 0);
               chk($sformatf("model_irq ch%0d cyc%0d", ch, cyc),  32'(irq_o[ch]),  32'(e_irq));
               chk($sformatf("model_busy ch%0d cyc%0d", ch, cyc), 32'(busy_o[ch]), 32'(e_busy));
               chk($sformatf("model_ovf ch%0d cyc%0d", ch, cyc),  32'(ovf_o[ch]),  32'(m_ovf[ch]));
               chk($sformatf("model_pend ch%0d cyc%0d", ch, cyc), pend_of(ch),     32'(m_pend[ch]));
            end
         end
         for (int ch = 0; ch < N; ch++)
            if (irq_o[ch] === 1'b1 && prev_irq[ch] !== 1'b1) rises[ch]++;
         prev_irq = irq_o;
      end
   end

   initial begin
      int r0;
      rst = 1'b1; stb = '0; en = '1; fl = '0; clr = '0;
      goto(1);
      chk("reset_irq",  32'(irq_o),  32'd0);
      chk("reset_busy", 32'(busy_o), 32'd0);
      chk("reset_ovf",  32'(ovf_o),  32'd0);
      chk("reset_pend", 32'(pend_o), 32'd0);
      goto(3); rst = 1'b0;

      // single strobe on channel 0
      goto(10); stb = 4'b0001;
      goto(11); stb = '0; chk("t1_irq_c11", 32'(irq_o[0]), 32'd1);
      goto(14); chk("t1_irq_c14", 32'(irq_o[0]), 32'd1);
      goto(15); chk("t1_irq_c15", 32'(irq_o[0]), 32'd0);
      goto(18); chk("t1_busy_c18", 32'(busy_o[0]), 32'd1);
      goto(19); chk("t1_busy_c19", 32'(busy_o[0]), 32'd0);

      // three back-to-back strobes on channel 1
      goto(30); stb = 4'b0010;
      goto(31); chk("t2_irq_c31", 32'(irq_o[1]), 32'd1);
      goto(32); chk("t2_pend_c32", pend_of(1), 32'd1);
      goto(33); stb = '0; chk("t2_pend_c33", pend_of(1), 32'd2);
      goto(38); chk("t2_irq_c38", 32'(irq_o[1]), 32'd0);
      goto(39); chk("t2_irq_c39", 32'(irq_o[1]), 32'd1); chk("t2_pend_c39", pend_of(1), 32'd1);
      goto(46); chk("t2_irq_c46", 32'(irq_o[1]), 32'd0);
      goto(47); chk("t2_irq_c47", 32'(irq_o[1]), 32'd1); chk("t2_pend_c47", pend_of(1), 32'd0);

      // saturation on channel 2
      goto(60); r0 = rises[2]; stb = 4'b0100;
      goto(64); chk("t3_pend_sat", pend_of(2), 32'd3);
      goto(66); stb = '0; chk("t3_ovf_set", 32'(ovf_o[2]), 32'd1);
      goto(95); chk("t3_pulses", 32'(rises[2] - r0), 32'd4);
      goto(100); clr = 4'b0100;
      goto(101); clr = '0; chk("t3_ovf_clr", 32'(ovf_o[2]), 32'd0);
      goto(110); stb = 4'b0100;
      goto(114); clr = 4'b0100;
      goto(115); stb = '0; clr = '0; chk("t3_set_wins", 32'(ovf_o[2]), 32'd1);
      goto(150); clr = 4'b0100;
      goto(151); clr = '0; chk("t3_ovf_clr2", 32'(ovf_o[2]), 32'd0);

      // flush during HIGH on channel 3
      goto(160); r0 = rises[3]; stb = 4'b1000;
      goto(163); chk("t4_pend_pre", pend_of(3), 32'd2); fl = 4'b1000;
      goto(164); stb = '0; fl = '0;
      chk("t4_irq_c164", 32'(irq_o[3]), 32'd1); chk("t4_pend_flushed", pend_of(3), 32'd0);
      goto(165); chk("t4_irq_c165", 32'(irq_o[3]), 32'd0);
      goto(169); chk("t4_busy_c169", 32'(busy_o[3]), 32'd0);
      goto(190); chk("t4_pulses", 32'(rises[3] - r0), 32'd1);

      // disabled strobe
      goto(200); en = 4'b1110; stb = 4'b0001;
      goto(201); stb = '0; en = '1;
      chk("t5_irq", 32'(irq_o[0]), 32'd0); chk("t5_pend", pend_of(0), 32'd0); chk("t5_busy", 32'(busy_o[0]), 32'd0);

      // all channels at once, then flush swallowing a strobe on an idle channel
      goto(210); stb = 4'b1111;
      goto(211); stb = '0; chk("all_ch_irq", 32'(irq_o), 32'hF);
      goto(230); stb = 4'b0001; fl = 4'b0001;
      goto(231); stb = '0; fl = '0; chk("flush_idle_busy", 32'(busy_o[0]), 32'd0);

      // asynchronous reset mid-pulse
      goto(250); stb = 4'b0010;
      goto(251); stb = '0;
      goto(252); chk("t6_irq_pre", 32'(irq_o[1]), 32'd1); rst = 1'b1;
      #1; chk("t6_irq_async", 32'(irq_o[1]), 32'd0);
      goto(255); rst = 1'b0;
      goto(256);
      chk("t6_irq",  32'(irq_o),  32'd0);
      chk("t6_busy", 32'(busy_o), 32'd0);
      chk("t6_ovf",  32'(ovf_o),  32'd0);
      chk("t6_pend", 32'(pend_o), 32'd0);

      // five strobes during one pulse on channel 0
      goto(270); r0 = rises[0]; stb = 4'b0001;
      goto(275); stb = '0;
      goto(310);
`ifdef DMA_IRQ_EVENT_COALESCE_EN
      chk("t7_pulses", 32'(rises[0] - r0), 32'd2);
      chk("t7_ovf", 32'(ovf_o[0]), 32'd0);
`else
      chk("t7_pulses", 32'(rises[0] - r0), 32'd4);
      chk("t7_ovf", 32'(ovf_o[0]), 32'd1);
`endif

      goto(320);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dma_interrupt_event_gen.md
# dma_interrupt_event_gen

- Source side of the DMA interrupt path.
- Converts single-cycle completion strobes from the DMA engines into clean, rate-limited interrupt event pulses. The interrupt controller's synchronizer and rising-edge detector capture each of these pulses as exactly one event.
- Queues bursts of strobes per channel, so back-to-back completions are never merged into one rising edge.
- Sits between the DMA channel engines and the interrupt controller's `interrupt_event_i` bus.

## Interface
Parameters:
- NUM_EVENTS, 4, number of event channels; equals the interrupt controller register width
- PULSE_HIGH, 4, cycles each event pulse is held high; legal range 1..255
- PULSE_LOW, 4, minimum low cycles after each pulse; legal range 1..255
- PEND_W, 5, width of each per-channel pending counter

Ports:
- sys_clk_i  in  1  system clock; all logic is on this single clock domain
- rst_i  in  1  reset, asynchronous and active-high
- event_strobe_i  in  NUM_EVENTS  one-cycle completion strobe per channel
- event_en_i  in  NUM_EVENTS  per-channel accept enable
- flush_i  in  NUM_EVENTS  per-channel pulse that discards pending events
- overflow_clr_i  in  NUM_EVENTS  per-channel pulse that clears the sticky overflow flag
- interrupt_event_o  out  NUM_EVENTS  registered event pulses to the interrupt controller
- busy_o  out  NUM_EVENTS  channel FSM not IDLE, or pending count nonzero
- overflow_o  out  NUM_EVENTS  sticky flag: a strobe was dropped
- pending_cnt_o  out  NUM_EVENTS*PEND_W  pending counts, concatenated; channel k at [k*PEND_W +: PEND_W]

## Operation
- Each channel is independent and has:
  - an FSM with states IDLE, HIGH, GAP
  - an 8-bit phase counter
  - a PEND_W-bit pending counter
- A strobe is accepted when `event_strobe_i[k] && event_en_i[k]`. Other strobes are ignored and leave no trace.
- Launch condition: (IDLE or last GAP cycle) and (pending != 0 or accepted strobe).
- FSM transitions:
  - IDLE → HIGH on launch. Phase counter loads PULSE_HIGH-1. `interrupt_event_o` is 1 while in HIGH.
  - HIGH → GAP when the phase counter reaches 0. Phase counter loads PULSE_LOW-1.
  - GAP → HIGH when the phase counter reaches 0 and launch holds.
  - GAP → IDLE when the phase counter reaches 0 and launch does not hold.
- Pending counter update:
  - +1 on an accepted strobe that is not itself launched this cycle.
  - −1 on a launch that consumes a queued event.
  - An accepted strobe and a consuming launch in the same cycle give a net change of 0; the strobe is queued and the oldest event is launched.
- Saturation:
  - The counter saturates at 2^PEND_W−1.
  - An accepted strobe arriving at saturation with no simultaneous consuming launch is dropped, and `overflow_o[k]` is set.
- `overflow_o[k]`:
  - Cleared only by `overflow_clr_i[k]` or by reset.
  - If set and clear occur in the same cycle, set wins.
- `flush_i[k]`:
  - Forces the pending counter to 0 and cancels any launch decision in that cycle.
  - An accepted strobe in the flush cycle is also discarded.
  - An in-progress HIGH or GAP always completes, so a pulse is never truncated.

## Timing
- Reset values:
  - `interrupt_event_o`, `busy_o`, `overflow_o`, `pending_cnt_o` are all 0.
  - All FSMs are IDLE; all counters are 0.
- Reset asserted mid-pulse drops the output to 0 immediately and asynchronously.
- Latency: a strobe accepted at cycle t on an idle channel with pending = 0 drives the output high in cycles t+1 .. t+PULSE_HIGH and low in cycles t+PULSE_HIGH+1 .. t+PULSE_HIGH+PULSE_LOW.
- Back-to-back pulse period is exactly PULSE_HIGH+PULSE_LOW cycles; no extra IDLE cycle between pulses.
- All outputs are registered.
- `pending_cnt_o` and `busy_o` reflect the post-update state one cycle after the causing input.
- Channels never interact.

## Configuration
- Macro: `DMA_IRQ_EVENT_COALESCE_EN`.
- Defined:
  - The pending counter behaves as a 1-bit flag; any number of strobes while busy collapses into one queued pulse.
  - Overflow is never set.
  - `pending_cnt_o` reads 0 or 1.
- Undefined: the full counting and saturation behaviour described above applies.

## Test plan
- Single strobe, channel 0 idle, PULSE_HIGH=4, PULSE_LOW=4, strobe at cycle 10:
  - output is high in cycles 11–14 and low from cycle 15;
  - `busy_o` drops at cycle 19.
- Three strobes on consecutive cycles 10, 11, 12:
  - three pulses rising at cycles 11, 19, 27;
  - pending count reads 1, 2, 1, 0 at the relevant cycles.
- PEND_W=2 with 6 rapid strobes during the first pulse:
  - pending count saturates at 3 and `overflow_o` is set;
  - exactly 4 pulses are emitted in total;
  - `overflow_clr_i` then clears the flag.
- flush_i asserted during HIGH with pending=2:
  - the current pulse completes its full 4 cycles;
  - pending goes to 0 and no further pulses are emitted.
- `event_en_i`=0 during a strobe: no pulse and no count change. rst_i asserted mid-HIGH: output is 0 immediately, and all outputs stay at their reset values after release.
- With `DMA_IRQ_EVENT_COALESCE_EN` defined, 5 strobes during one pulse: exactly 2 pulses in total and `overflow_o` stays 0.
